// File: rtl/bram_cfg_pkg.sv
// Shared definitions for the BRAM configuration-chain loader.
//   ccff_state_e : loader FSM states
//   cnt_w()      : width of a counter that must hold 0..n without wrapping
package bram_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ccff_state_e;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: holds one bitstream word and presents it LSB first.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : empty the register (new load / abort)
//   load          : capture load_data with load_cnt valid bits
//   shift_en      : consume the current bit (ignored when empty)
//   head          : current bit (register bit 0)
//   occ_nz        : at least one valid bit is held
module ccff_word_serializer #(
  parameter int WORD_W = 8,
  parameter int OCC_W  = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [OCC_W-1:0]  load_cnt,
  input  logic              shift_en,
  output logic              head,
  output logic              occ_nz
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  always_comb begin
    sr_d  = sr_q;
    occ_d = occ_q;
    if (clear) begin
      sr_d  = '0;
      occ_d = '0;
    end else if (load) begin
      sr_d  = load_data;
      occ_d = load_cnt;
    end else if (shift_en && (occ_q != '0)) begin
      sr_d  = sr_q >> 1;
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      occ_q <= '0;
    end else begin
      sr_q  <= sr_d;
      occ_q <= occ_d;
    end
  end

  assign head   = sr_q[0];
  assign occ_nz = (occ_q != '0);

endmodule

// File: rtl/bram_ccff_loader.sv
// Streams a bitstream into a BRAM-tile configuration flip-flop chain.
//   prog_clock, prog_reset : clock, synchronous active-high reset
//   start, abort           : begin / cancel a load
//   s_valid, s_data, s_ready : word stream in (LSB first)
//   ccff_head, config_enable : serial bit and shift enable to chain head
//   ccff_tail              : old chain contents shifted out
//   busy, done             : status; done pulses one cycle on completion
//   old_parity             : XOR of the bits displaced by the last full load
//   err_start              : sticky, start seen while busy
module bram_ccff_loader
  import bram_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clock,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              old_parity,
  output logic              err_start
);

  localparam int CW = cnt_w(CHAIN_LEN);
  localparam int OW = $clog2(WORD_W + 1);
  localparam logic [CW-1:0] CHAIN_C = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] LAST_C  = CW'(CHAIN_LEN - 1);

  ccff_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          par_q, par_d;
  logic          err_q, err_d;

  logic          occ_nz, ser_clear, accept;
  logic [CW-1:0] rem;
  logic [OW-1:0] load_cnt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    par_d     = par_q;
    err_d     = err_q;
    ser_clear = 1'b0;

    s_ready       = (state_q == ST_SHIFT) && !occ_nz && (cnt_q < CHAIN_C);
    config_enable = (state_q == ST_SHIFT) && occ_nz;
    accept        = s_ready && s_valid;

    // Final word is trimmed so surplus bits are never presented.
    rem      = CHAIN_C - cnt_q;
    load_cnt = (int'(rem) >= WORD_W) ? OW'(WORD_W) : OW'(rem);

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_SHIFT;
          cnt_d     = '0;
          acc_d     = 1'b0;
          err_d     = 1'b0;
          ser_clear = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          ser_clear = 1'b1;
        end else if (config_enable) begin
          cnt_d = cnt_q + CW'(1);
          acc_d = acc_q ^ ccff_tail;
          if (cnt_q == LAST_C) begin
            state_d = ST_DONE;
            par_d   = acc_q ^ ccff_tail;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (start && (state_q != ST_IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge prog_clock) begin
    if (prog_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      par_q   <= par_d;
      err_q   <= err_d;
    end
  end

  ccff_word_serializer #(.WORD_W(WORD_W), .OCC_W(OW)) u_ser (
    .clk       (prog_clock),
    .rst       (prog_reset),
    .clear     (ser_clear),
    .load      (accept),
    .load_data (s_data),
    .load_cnt  (load_cnt),
    .shift_en  (config_enable),
    .head      (ccff_head),
    .occ_nz    (occ_nz)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign old_parity = par_q;
  assign err_start  = err_q;

endmodule
